// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the external program memory arbiter.
package mem_arb_pkg;

   localparam int ADR_W  = 21;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } state_t;

   typedef enum logic {
      LD,
      CPU
   } owner_t;

endpackage

// File: rtl/mem_arb_ld_buf.sv
// Single-entry holding register for loader writes that could not be granted
// on arrival; a fill while already occupied is dropped and flagged as overrun.
module mem_arb_ld_buf
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fill,
   input  logic              take,
   input  logic [ADR_W-1:0]  fill_adr,
   input  logic [DATA_W-1:0] fill_data,
   output logic              valid,
   output logic              overrun,
   output logic [ADR_W-1:0]  adr,
   output logic [DATA_W-1:0] data
);

   logic              valid_reg, valid_next;
   logic              overrun_reg, overrun_next;
   logic [ADR_W-1:0]  adr_reg, adr_next;
   logic [DATA_W-1:0] data_reg, data_next;

   // A take in the same cycle frees the slot, so a simultaneous fill is kept.
   always_comb begin
      valid_next   = valid_reg;
      overrun_next = overrun_reg;
      adr_next     = adr_reg;
      data_next    = data_reg;
      if (take) begin
         valid_next = 1'b0;
      end
      if (fill) begin
         if (!valid_reg || take) begin
            valid_next = 1'b1;
            adr_next   = fill_adr;
            data_next  = fill_data;
         end else begin
            overrun_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
         adr_reg     <= '0;
         data_reg    <= '0;
      end else begin
         valid_reg   <= valid_next;
         overrun_reg <= overrun_next;
         adr_reg     <= adr_next;
         data_reg    <= data_next;
      end
   end

   assign valid   = valid_reg;
   assign overrun = overrun_reg;
   assign adr     = adr_reg;
   assign data    = data_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the external program memory between loader writes (priority,
// buffered) and CPU req/ack accesses. MEM_ARB_STATS_EN adds ld_overrun/ld_count.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STROBE_CYCLES = 1
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADR_W-1:0]  ld_adr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_write,
   input  logic              ld_active,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADR_W-1:0]  cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic [ADR_W-1:0]  mem_adr,
   output logic [DATA_W-1:0] mem_dout,
   output logic              mem_drive,
   output logic              mem_we,
   output logic              mem_oe,
`ifdef MEM_ARB_STATS_EN
   output logic              ld_overrun,
   output logic [ADR_W-1:0]  ld_count,
`endif
   input  logic [DATA_W-1:0] mem_din
);

   localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);

   state_t            state_reg, state_next;
   owner_t            owner_reg, owner_next;
   logic [2:0]        cnt_reg, cnt_next;
   logic              is_wr_reg, is_wr_next;
   logic [ADR_W-1:0]  mem_adr_reg, mem_adr_next;
   logic [DATA_W-1:0] mem_dout_reg, mem_dout_next;
   logic              mem_drive_reg, mem_drive_next;
   logic              mem_we_reg, mem_we_next;
   logic              mem_oe_reg, mem_oe_next;
   logic              cpu_ack_reg, cpu_ack_next;
   logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;

   logic              buf_valid, buf_overrun, buf_fill, buf_take;
   logic [ADR_W-1:0]  buf_adr;
   logic [DATA_W-1:0] buf_data;
   logic              strobe_last;

   // A pulse is granted directly only when idle with nothing already waiting.
   assign buf_fill    = ld_write && !((state_reg == IDLE) && !buf_valid);
   assign strobe_last = (cnt_reg == STROBE_LAST);

   mem_arb_ld_buf u_ld_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .fill      (buf_fill),
      .take      (buf_take),
      .fill_adr  (ld_adr),
      .fill_data (ld_data),
      .valid     (buf_valid),
      .overrun   (buf_overrun),
      .adr       (buf_adr),
      .data      (buf_data)
   );

   always_comb begin
      state_next     = state_reg;
      owner_next     = owner_reg;
      cnt_next       = cnt_reg;
      is_wr_next     = is_wr_reg;
      mem_adr_next   = mem_adr_reg;
      mem_dout_next  = mem_dout_reg;
      mem_drive_next = mem_drive_reg;
      mem_we_next    = 1'b0;
      mem_oe_next    = 1'b0;
      cpu_ack_next   = 1'b0;
      cpu_rdata_next = cpu_rdata_reg;
      buf_take       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (buf_valid) begin
               buf_take       = 1'b1;
               state_next     = SETUP;
               owner_next     = LD;
               is_wr_next     = 1'b1;
               mem_adr_next   = buf_adr;
               mem_dout_next  = buf_data;
               mem_drive_next = 1'b1;
            end else if (ld_write) begin
               state_next     = SETUP;
               owner_next     = LD;
               is_wr_next     = 1'b1;
               mem_adr_next   = ld_adr;
               mem_dout_next  = ld_data;
               mem_drive_next = 1'b1;
            end else if (cpu_req && !ld_active) begin
               state_next     = SETUP;
               owner_next     = CPU;
               is_wr_next     = cpu_we;
               mem_adr_next   = cpu_adr;
               mem_dout_next  = cpu_wdata;
               mem_drive_next = cpu_we;
            end
         end
         SETUP: begin
            state_next  = STROBE;
            cnt_next    = '0;
            mem_we_next = is_wr_reg;
            mem_oe_next = !is_wr_reg;
         end
         STROBE: begin
            if (strobe_last) begin
               state_next   = HOLD;
               cpu_ack_next = (owner_reg == CPU);
               if (!is_wr_reg) begin
                  cpu_rdata_next = mem_din;
               end
            end else begin
               cnt_next    = cnt_reg + 3'd1;
               mem_we_next = is_wr_reg;
               mem_oe_next = !is_wr_reg;
            end
         end
         HOLD: begin
            state_next     = IDLE;
            mem_drive_next = 1'b0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         owner_reg     <= LD;
         cnt_reg       <= '0;
         is_wr_reg     <= 1'b0;
         mem_adr_reg   <= '0;
         mem_dout_reg  <= '0;
         mem_drive_reg <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_oe_reg    <= 1'b0;
         cpu_ack_reg   <= 1'b0;
         cpu_rdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         owner_reg     <= owner_next;
         cnt_reg       <= cnt_next;
         is_wr_reg     <= is_wr_next;
         mem_adr_reg   <= mem_adr_next;
         mem_dout_reg  <= mem_dout_next;
         mem_drive_reg <= mem_drive_next;
         mem_we_reg    <= mem_we_next;
         mem_oe_reg    <= mem_oe_next;
         cpu_ack_reg   <= cpu_ack_next;
         cpu_rdata_reg <= cpu_rdata_next;
      end
   end

   assign mem_adr   = mem_adr_reg;
   assign mem_dout  = mem_dout_reg;
   assign mem_drive = mem_drive_reg;
   assign mem_we    = mem_we_reg;
   assign mem_oe    = mem_oe_reg;
   assign cpu_ack   = cpu_ack_reg;
   assign cpu_rdata = cpu_rdata_reg;

`ifdef MEM_ARB_STATS_EN
   logic [ADR_W-1:0] ld_count_reg;
   logic             ld_done;

   assign ld_done = (state_reg == STROBE) && strobe_last && (owner_reg == LD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ld_count_reg <= '0;
      end else if (ld_done) begin
         ld_count_reg <= ld_count_reg + 1'b1;
      end
   end

   assign ld_count   = ld_count_reg;
   assign ld_overrun = buf_overrun;
`else
   logic overrun_unused;
   assign overrun_unused = buf_overrun;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle vector table plus hand
// sequences for the load stream, overrun and mid-access reset.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [ADR_W-1:0]  ld_adr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_write, ld_active;
   logic              cpu_req, cpu_we;
   logic [ADR_W-1:0]  cpu_adr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              cpu_ack;
   logic [ADR_W-1:0]  mem_adr;
   logic [DATA_W-1:0] mem_dout, mem_din;
   logic              mem_drive, mem_we, mem_oe;
`ifdef MEM_ARB_STATS_EN
   logic              ld_overrun;
   logic [ADR_W-1:0]  ld_count;
`endif

   mem_arbiter #(.STROBE_CYCLES(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ld_adr    (ld_adr),
      .ld_data   (ld_data),
      .ld_write  (ld_write),
      .ld_active (ld_active),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_adr   (cpu_adr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .mem_adr   (mem_adr),
      .mem_dout  (mem_dout),
      .mem_drive (mem_drive),
      .mem_we    (mem_we),
      .mem_oe    (mem_oe),
`ifdef MEM_ARB_STATS_EN
      .ld_overrun(ld_overrun),
      .ld_count  (ld_count),
`endif
      .mem_din   (mem_din)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              lw;
      logic [ADR_W-1:0]  ladr;
      logic [DATA_W-1:0] ldat;
      logic              lact;
      logic              creq;
      logic              cwe;
      logic [ADR_W-1:0]  cadr;
      logic [DATA_W-1:0] cwd;
      logic [DATA_W-1:0] din;
      logic [ADR_W-1:0]  madr;
      logic [DATA_W-1:0] mdout;
      logic              drive;
      logic              we;
      logic              oe;
      logic              ack;
      logic [DATA_W-1:0] rdata;
   } vec_t;

   typedef struct {
      logic [ADR_W-1:0]  adr;
      logic [DATA_W-1:0] data;
      logic              drive;
   } wr_t;

   int   checks = 0;
   int   failures = 0;
   int   ack_cnt = 0;
   wr_t  wr_q[$];
   vec_t vecs [25];

   // Observe the memory pins and ack away from the active edge.
   always @(negedge clk) begin
      wr_t w;
      if (mem_we) begin
         w.adr   = mem_adr;
         w.data  = mem_dout;
         w.drive = mem_drive;
         wr_q.push_back(w);
      end
      if (cpu_ack) ack_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] outs();
      return {23'b0, mem_adr, mem_dout, mem_drive, mem_we, mem_oe, cpu_ack, cpu_rdata};
   endfunction

   function automatic logic [63:0] exp_outs(input vec_t v);
      return {23'b0, v.madr, v.mdout, v.drive, v.we, v.oe, v.ack, v.rdata};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ack(input int limit, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < limit && !seen; n++) begin
         @(negedge clk);
         if (cpu_ack) seen = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("reset_outputs", outs(), 64'd0);
`ifdef MEM_ARB_STATS_EN
      check("reset_stats", {42'd0, ld_overrun, ld_count}, 64'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic ld_pulse(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
      ld_write = 1'b1;
      ld_adr   = a;
      ld_data  = d;
   endtask

   initial begin
      bit seen;
      int a0;
      int bad;
      int first_bad;

      reset_n = 1'b0;
      ld_adr = '0; ld_data = '0; ld_write = 1'b0; ld_active = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0; mem_din = '0;

      //          lw  ladr        ldat   lact creq cwe  cadr        cwd    din    | madr        mdout  dr   we   oe   ack  rdata
      vecs[0]  = '{1'b1, 21'h00010, 8'hA5, 1'b0, 1'b0, 1'b0, 21'h00000, 8'h00, 8'h3C, 21'h00000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b0, 1'b0, 21'h00000, 8'h00, 8'h3C, 21'h00010, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b0, 1'b0, 21'h00000, 8'h00, 8'h3C, 21'h00010, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b0, 1'b0, 21'h00000, 8'h00, 8'h3C, 21'h00010, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4]  = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 21'h1ABCD, 8'h00, 8'h3C, 21'h00010, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[5]  = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 21'h1ABCD, 8'h00, 8'h3C, 21'h1ABCD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[6]  = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 21'h1ABCD, 8'h00, 8'h3C, 21'h1ABCD, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[7]  = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 21'h1ABCD, 8'h00, 8'h3C, 21'h1ABCD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
      vecs[8]  = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b0, 1'b0, 21'h00000, 8'h00, 8'h55, 21'h1ABCD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[9]  = '{1'b1, 21'h1FFFFF, 8'h5A, 1'b0, 1'b1, 1'b1, 21'h00123, 8'hC3, 8'h55, 21'h1ABCD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[10] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b1, 21'h00123, 8'hC3, 8'h55, 21'h1FFFFF, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[11] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b1, 21'h00123, 8'hC3, 8'h55, 21'h1FFFFF, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
      vecs[12] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b1, 21'h00123, 8'hC3, 8'h55, 21'h1FFFFF, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[13] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b1, 21'h00123, 8'hC3, 8'h55, 21'h1FFFFF, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[14] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b1, 21'h00123, 8'hC3, 8'h55, 21'h00123, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[15] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b1, 21'h00123, 8'hC3, 8'h55, 21'h00123, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
      vecs[16] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b1, 21'h00123, 8'hC3, 8'h55, 21'h00123, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
      vecs[17] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b0, 1'b0, 21'h00000, 8'h00, 8'h55, 21'h00123, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[18] = '{1'b0, 21'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 21'h00200, 8'h00, 8'h66, 21'h00123, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[19] = '{1'b0, 21'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 21'h00200, 8'h00, 8'h66, 21'h00123, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[20] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 21'h00200, 8'h00, 8'h66, 21'h00123, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[21] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 21'h00200, 8'h00, 8'h66, 21'h00200, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[22] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 21'h00200, 8'h00, 8'h66, 21'h00200, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
      vecs[23] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 21'h00200, 8'h00, 8'h66, 21'h00200, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66};
      vecs[24] = '{1'b0, 21'h00000, 8'h00, 1'b0, 1'b0, 1'b0, 21'h00000, 8'h00, 8'h66, 21'h00200, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66};

      do_reset();

      // Single load write, CPU read, collision, ld_active lockout.
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         ld_write  = vecs[i].lw;
         ld_adr    = vecs[i].ladr;
         ld_data   = vecs[i].ldat;
         ld_active = vecs[i].lact;
         cpu_req   = vecs[i].creq;
         cpu_we    = vecs[i].cwe;
         cpu_adr   = vecs[i].cadr;
         cpu_wdata = vecs[i].cwd;
         mem_din   = vecs[i].din;
         #1;
         check($sformatf("vec%0d", i), outs(), exp_outs(vecs[i]));
         $display("vec %0d: adr=%h dout=%h drv=%b we=%b oe=%b ack=%b rdata=%h",
                  i, mem_adr, mem_dout, mem_drive, mem_we, mem_oe, cpu_ack, cpu_rdata);
      end

      // 256-byte stream with ld_active=1 and a CPU read held pending.
      do_reset();
      @(negedge clk);
      ld_active = 1'b1;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_adr   = 21'h00777;
      mem_din   = 8'h77;
      wr_q.delete();
      a0 = ack_cnt;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         ld_pulse(21'h10000 + 21'(i), 8'(i) ^ 8'h5A);
         @(negedge clk);
         ld_write = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("stream_count", 64'(wr_q.size()), 64'd256);
      bad = 0;
      first_bad = -1;
      for (int i = 0; i < wr_q.size() && i < 256; i++) begin
         if (wr_q[i].adr !== 21'h10000 + 21'(i) || wr_q[i].data !== (8'(i) ^ 8'h5A) || wr_q[i].drive !== 1'b1) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      check("stream_order_bad_entries", 64'(bad), 64'd0);
      if (bad != 0) $display("stream first bad index %0d", first_bad);
      check("stream_no_ack", 64'(ack_cnt - a0), 64'd0);
`ifdef MEM_ARB_STATS_EN
      check("stream_overrun", {63'd0, ld_overrun}, 64'd0);
      check("stream_ld_count", {43'd0, ld_count}, 64'd256);
`endif
      $display("stream: writes=%0d acks=%0d", wr_q.size(), ack_cnt - a0);
      ld_active = 1'b0;
      wait_ack(8, seen);
      check("stream_cpu_ack_after_release", {63'd0, seen}, 64'd1);
      check("stream_cpu_rdata", {56'd0, cpu_rdata}, 64'h77);
      cpu_req = 1'b0;
      $display("post-stream read: ack=%b rdata=%h", seen, cpu_rdata);

      // Overrun: three loader pulses two cycles apart during a CPU read.
      repeat (2) @(negedge clk);
      wr_q.delete();
      a0 = ack_cnt;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 21'h00300; mem_din = 8'h99;
      @(negedge clk);
      @(negedge clk);
      ld_pulse(21'h00400, 8'h11);
      @(negedge clk);
      ld_write = 1'b0;
      check("ovr_ack_in_hold", {63'd0, cpu_ack}, 64'd1);
      cpu_req = 1'b0;
      @(negedge clk);
      ld_pulse(21'h00401, 8'h22);
      @(negedge clk);
      ld_write = 1'b0;
      @(negedge clk);
      ld_pulse(21'h00402, 8'h33);
      @(negedge clk);
      ld_write = 1'b0;
      repeat (12) @(negedge clk);
      check("ovr_ack_count", 64'(ack_cnt - a0), 64'd1);
      check("ovr_rdata", {56'd0, cpu_rdata}, 64'h99);
      check("ovr_write_count", 64'(wr_q.size()), 64'd2);
      if (wr_q.size() >= 2) begin
         check("ovr_write0", {35'd0, wr_q[0].adr, wr_q[0].data}, {35'd0, 21'h00400, 8'h11});
         check("ovr_write1", {35'd0, wr_q[1].adr, wr_q[1].data}, {35'd0, 21'h00401, 8'h22});
      end
`ifdef MEM_ARB_STATS_EN
      check("ovr_flag", {63'd0, ld_overrun}, 64'd1);
`endif
      $display("overrun: writes=%0d acks=%0d rdata=%h", wr_q.size(), ack_cnt - a0, cpu_rdata);

      // Reset asserted during the STROBE of a CPU write.
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 21'h00555; cpu_wdata = 8'hEE;
      @(negedge clk);
      @(negedge clk);
      check("rst_strobe_we_high", {63'd0, mem_we}, 64'd1);
      a0 = ack_cnt;
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_outputs", outs(), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check("rst_no_ack", 64'(ack_cnt - a0), 64'd0);
      reset_n = 1'b1;
      wr_q.delete();
      wait_ack(10, seen);
      check("rst_reissue_ack", {63'd0, seen}, 64'd1);
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_reissue_writes", 64'(wr_q.size()), 64'd1);
      if (wr_q.size() >= 1) begin
         check("rst_reissue_write", {34'd0, wr_q[0].drive, wr_q[0].adr, wr_q[0].data},
               {34'd0, 1'b1, 21'h00555, 8'hEE});
      end
      $display("reset mid-access: reissue ack=%b writes=%0d", seen, wr_q.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the 21-bit × 8-bit external program memory between the UART program loader's write port and the CPU's memory port. It runs a fixed SETUP/STROBE/HOLD cycle on the memory pins. Loader writes take strict priority and are buffered so that no byte is lost. CPU requests use a req/ack handshake and are locked out while a load session is active.

## Interface
Parameters:
- STROBE_CYCLES, 1: cycles mem_we/mem_oe stay asserted per access (1..7)

Ports:
- clk  in  1  system clock; loader and CPU are synchronous to it
- reset_n  in  1  asynchronous, active-low reset
- ld_adr  in  21  loader byte address, valid while ld_write=1
- ld_data  in  8  loader byte, valid while ld_write=1
- ld_write  in  1  one-cycle write pulse; pulses are ≥4 cycles apart
- ld_active  in  1  load session in progress (level)
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req=1
- cpu_adr  in  21  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data; valid from cpu_ack, held until the next read ack
- cpu_ack  out  1  one-cycle completion pulse
- mem_adr  out  21  memory address
- mem_dout  out  8  memory write data
- mem_drive  out  1  data pin output enable (writes only)
- mem_we  out  1  write strobe, active-high
- mem_oe  out  1  read strobe, active-high
- mem_din  in  8  memory read data

## Operation
- State machine states: IDLE, SETUP, STROBE, HOLD. All memory outputs are registered.
- In IDLE, the arbiter picks the next access in this order:
  1. a pending loader write;
  2. a loader write arriving this cycle;
  3. cpu_req, but only if ld_active=0 and no loader write is pending.
  With no winner, the state stays IDLE.
- A grant moves the state to SETUP. mem_adr, mem_dout and mem_drive are driven; mem_drive=1 only for writes.
- SETUP → STROBE. In STROBE, mem_we (write) or mem_oe (read) is high for STROBE_CYCLES cycles, tracked by a 3-bit counter.
- On the final STROBE edge, a read captures mem_din into cpu_rdata. The state then moves to HOLD.
- In HOLD, the strobes are low while address, data and drive are held. cpu_ack=1 during HOLD for CPU accesses only. HOLD → IDLE.
- Loader buffer: one entry (address + data + valid). It is filled by any ld_write pulse not granted the same cycle, and cleared when its access is granted.
- Overrun: a ld_write arriving while the buffer is already valid is dropped, and ld_overrun is set.
- An in-flight CPU access always completes, even if ld_active rises mid-cycle. The loader write waits in the buffer.
- cpu_req dropping before ack is illegal. Behaviour in that case is undefined, and the bench does not exercise it.

## Timing
- Access length: 1 SETUP + STROBE_CYCLES + 1 HOLD, plus 1 IDLE cycle. The default is 4 cycles, which matches the loader's minimum pulse spacing.
- Loader write latency with the port idle: ld_write at cycle N → SETUP at N+1 → mem_we high at N+2.
- Worst-case CPU ack after cpu_req, ld_active=0, port idle: SETUP at +1, ack at +2+STROBE_CYCLES.
- Reset (async, reset_n=0), values take effect immediately:
  - state IDLE, buffer empty;
  - mem_we, mem_oe, mem_drive, cpu_ack = 0;
  - mem_adr, mem_dout, cpu_rdata = 0.
- Reset mid-access aborts the access with no ack. The CPU must re-request after reset.

## Configuration
- MEM_ARB_STATS_EN defined:
  - adds output ld_overrun (1 bit, sticky until reset);
  - adds output ld_count (21 bits), incremented on each loader access entering HOLD, wraps at 2^21.
- Undefined: neither port exists, and overrun bytes are still dropped silently.

## Structure
- Package mem_arb_pkg contains:
  - the state enum (IDLE/SETUP/STROBE/HOLD);
  - an owner enum (LD/CPU);
  - ADR_W=21 and DATA_W=8.
- Sub-module mem_arb_ld_buf: the single-entry loader holding register. It has fill, take, valid, overrun and data outputs, with the same clk/reset_n.

## Test plan
- Single loader write: ld_write with adr 0x00010 and data 0xA5 → mem_we high exactly 1 cycle at N+2, with mem_adr=0x00010, mem_dout=0xA5 and mem_drive=1.
- CPU read with ld_active=0 and mem_din=0x3C → mem_oe for 1 cycle, then cpu_ack 1 cycle with cpu_rdata=0x3C that stays held afterwards.
- Collision: ld_write on the same cycle as cpu_req → loader granted first, CPU ack 4 cycles later, both accesses correct.
- ld_active=1 with cpu_req held: a 256-byte stream at 4-cycle spacing → all 256 bytes written in order, no cpu_ack, ld_overrun=0, ld_count=256. Dropping ld_active then lets the CPU ack.
- Overrun: ld_write pulses 2 cycles apart three times during a CPU access → third byte dropped, ld_overrun=1.
- Reset asserted during STROBE → mem_we=0 immediately, no ack, all outputs 0. After release, the held cpu_req is served normally.
